// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, state codes,
// datapath select encodings and the opcode decode helpers.
package multi_cycle_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EX_MA  = 4'd2,
    S_MEM_RD = 4'd3,
    S_WB_MEM = 4'd4,
    S_MEM_WR = 4'd5,
    S_EX_R   = 4'd6,
    S_WB_R   = 4'd7,
    S_EX_I   = 4'd8,
    S_WB_I   = 4'd9,
    S_EX_BEQ = 4'd10,
    S_EX_J   = 4'd11
  } state_t;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // MEM_LAT is limited to 0..7, so three bits cover the wait counter.
  localparam int LAT_W = 3;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_legal = 1'b1;
      default:                                   op_legal = 1'b0;
    endcase
  endfunction

  // LED class is one-hot over J/BEQ/LW/SW/R; ADDI has no LED of its own.
  function automatic logic [4:0] op_class(input logic [5:0] op);
    case (op)
      OP_J:    op_class = 5'b10000;
      OP_BEQ:  op_class = 5'b01000;
      OP_LW:   op_class = 5'b00100;
      OP_SW:   op_class = 5'b00010;
      OP_R:    op_class = 5'b00001;
      default: op_class = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_wait_cnt.sv
// Wait-phase down-counter used to stretch IF and MEM_RD over MEM_LAT+1 cycles.
// It rests at zero, loads the latency on the first cycle of a phase and
// counts down; done marks the final cycle of the phase.
module multi_wait_cnt
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int W = LAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] lat,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load on the first phase cycle, then decrement back down to the rest value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == '0) ? lat : cnt - W'(1);
    end
  end

  // At rest only a zero latency finishes at once; otherwise the last count is 1.
  assign done = (cnt == '0) ? (lat == '0) : (cnt == W'(1));

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath. Outputs are decoded from the
// registered state; write strobes are gated by en and everything by rst so a
// stall or reset silences the datapath without waiting for a clock edge.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [5:0]       OP,
  input  logic             zero,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic [4:0]       LED,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [LAT_W-1:0] LAT = LAT_W'(MEM_LAT);

  state_t st;
  ctl_t   ctl;
  logic   wait_en;
  logic   wait_done;

  // The zero flag qualifies PCWriteCond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_en = en && ((st == S_IF) || (st == S_MEM_RD));

  multi_wait_cnt #(.W(LAT_W)) u_wait (
    .clk  (clk),
    .rst  (rst),
    .en   (wait_en),
    .lat  (LAT),
    .done (wait_done)
  );

  // State sequencing, LED class latch and retirement count; all frozen by en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= S_IF;
      LED       <= '0;
      instr_cnt <= '0;
    end else if (en) begin
      case (st)
        S_IF:     if (wait_done) st <= S_ID;
        S_ID: begin
          LED <= op_class(OP);
          case (OP)
            OP_R:         st <= S_EX_R;
            OP_LW, OP_SW: st <= S_EX_MA;
            OP_BEQ:       st <= S_EX_BEQ;
            OP_J:         st <= S_EX_J;
            OP_ADDI:      st <= S_EX_I;
            default:      st <= S_IF;
          endcase
        end
        S_EX_MA:  st <= (OP == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD: if (wait_done) st <= S_WB_MEM;
        S_EX_R:   st <= S_WB_R;
        S_EX_I:   st <= S_WB_I;
        S_WB_MEM, S_MEM_WR, S_WB_R, S_WB_I, S_EX_BEQ, S_EX_J: begin
          st        <= S_IF;
          instr_cnt <= instr_cnt + CNT_W'(1);
        end
        default:  st <= S_IF;
      endcase
    end
  end

  // Moore decode of the datapath controls, then stall and reset gating.
  always_comb begin
    ctl = '0;
    case (st)
      S_IF: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.pc_source = PCSRC_ALU;
        ctl.ir_write  = wait_done;
        ctl.pc_write  = wait_done;
      end
      S_ID: begin
        ctl.alu_src_b = SRCB_SEXT_SH;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_EX_MA, S_EX_I: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_SEXT;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.ior_d    = 1'b1;
      end
      S_WB_MEM: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write = 1'b1;
        ctl.ior_d     = 1'b1;
      end
      S_EX_R: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALUOP_FUNCT;
      end
      S_WB_R: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_WB_I: ctl.reg_write = 1'b1;
      S_EX_BEQ: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_B;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
      S_EX_J: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
    if (!en) begin
      ctl.pc_write      = 1'b0;
      ctl.pc_write_cond = 1'b0;
      ctl.ir_write      = 1'b0;
      ctl.mem_write     = 1'b0;
      ctl.reg_write     = 1'b0;
    end
    if (rst) begin
      ctl = '0;
    end
  end

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.ior_d;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign ALUop       = ctl.alu_op;
  assign PCSource    = ctl.pc_source;
  assign state       = st;
  assign illegal     = en && !rst && (st == S_ID) && !op_legal(OP);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: one instance at MEM_LAT=1 and one at MEM_LAT=0,
// each checked cycle by cycle against a phase-list model of each instruction.
module tb_multi_cycle_ctrl;

  localparam int CNT_W = 8;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000;

  localparam int ST_IF = 0, ST_ID = 1, ST_EX_MA = 2, ST_MEM_RD = 3, ST_WB_MEM = 4,
                 ST_MEM_WR = 5, ST_EX_R = 6, ST_WB_R = 7, ST_EX_I = 8, ST_WB_I = 9,
                 ST_EX_BEQ = 10, ST_EX_J = 11;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic [1:0] pcs;
  } exp_ctl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic zero = 1'b0;
  logic [1:0] en = 2'b00;
  logic [1:0][5:0] op = '0;
  logic [1:0] pc_write, pc_write_cond, ior_d, mem_read, mem_write, ir_write;
  logic [1:0] mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0][1:0] alu_src_b, alu_op, pc_source;
  logic [1:0][3:0] state;
  logic [1:0][4:0] led;
  logic [1:0][CNT_W-1:0] instr_cnt;

  int n_checks = 0;
  int n_fail = 0;
  string cur_test = "none";
  int seq[$];
  logic [1:0][4:0] led_exp = '0;
  logic [1:0][CNT_W-1:0] cnt_exp = '0;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.MEM_LAT(1), .CNT_W(CNT_W)) dut_lat1 (
    .clk(clk), .rst(rst), .en(en[0]), .OP(op[0]), .zero(zero),
    .PCWrite(pc_write[0]), .PCWriteCond(pc_write_cond[0]), .IorD(ior_d[0]),
    .MemRead(mem_read[0]), .MemWrite(mem_write[0]), .IRWrite(ir_write[0]),
    .MemtoReg(mem_to_reg[0]), .RegDst(reg_dst[0]), .RegWrite(reg_write[0]),
    .ALUSrcA(alu_src_a[0]), .ALUSrcB(alu_src_b[0]), .ALUop(alu_op[0]),
    .PCSource(pc_source[0]), .state(state[0]), .LED(led[0]),
    .illegal(illegal[0]), .instr_cnt(instr_cnt[0])
  );

  multi_cycle_ctrl #(.MEM_LAT(0), .CNT_W(CNT_W)) dut_lat0 (
    .clk(clk), .rst(rst), .en(en[1]), .OP(op[1]), .zero(zero),
    .PCWrite(pc_write[1]), .PCWriteCond(pc_write_cond[1]), .IorD(ior_d[1]),
    .MemRead(mem_read[1]), .MemWrite(mem_write[1]), .IRWrite(ir_write[1]),
    .MemtoReg(mem_to_reg[1]), .RegDst(reg_dst[1]), .RegWrite(reg_write[1]),
    .ALUSrcA(alu_src_a[1]), .ALUSrcB(alu_src_b[1]), .ALUop(alu_op[1]),
    .PCSource(pc_source[1]), .state(state[1]), .LED(led[1]),
    .illegal(illegal[1]), .instr_cnt(instr_cnt[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return (o == T_R) || (o == T_LW) || (o == T_SW) || (o == T_BEQ) ||
           (o == T_J) || (o == T_ADDI);
  endfunction

  function automatic logic [4:0] led_of(input logic [5:0] o);
    if (o == T_J)   return 5'b10000;
    if (o == T_BEQ) return 5'b01000;
    if (o == T_LW)  return 5'b00100;
    if (o == T_SW)  return 5'b00010;
    if (o == T_R)   return 5'b00001;
    return 5'b00000;
  endfunction

  function automatic logic [5:0] rand_legal();
    case ($urandom_range(0, 5))
      0: return T_R;
      1: return T_LW;
      2: return T_SW;
      3: return T_BEQ;
      4: return T_J;
      default: return T_ADDI;
    endcase
  endfunction

  // Expected controls for a phase: what the phase lists, everything else 0.
  function automatic exp_ctl_t exp_ctl(input int s, input bit fin, input bit e);
    exp_ctl_t c;
    c = '0;
    case (s)
      ST_IF:     begin c.mr = 1; c.asb = 2'b01; c.irw = fin; c.pcw = fin; end
      ST_ID:     c.asb = 2'b11;
      ST_EX_MA:  begin c.asa = 1; c.asb = 2'b10; end
      ST_MEM_RD: begin c.mr = 1; c.iord = 1; end
      ST_WB_MEM: begin c.rw = 1; c.m2r = 1; end
      ST_MEM_WR: begin c.mw = 1; c.iord = 1; end
      ST_EX_R:   begin c.asa = 1; c.aop = 2'b10; end
      ST_WB_R:   begin c.rw = 1; c.rdst = 1; end
      ST_EX_I:   begin c.asa = 1; c.asb = 2'b10; end
      ST_WB_I:   c.rw = 1;
      ST_EX_BEQ: begin c.asa = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; end
      ST_EX_J:   begin c.pcw = 1; c.pcs = 2'b10; end
      default: ;
    endcase
    if (!e) begin
      c.pcw = 0; c.pcwc = 0; c.irw = 0; c.mw = 0; c.rw = 0;
    end
    return c;
  endfunction

  function automatic exp_ctl_t obs_ctl(input int d);
    return {pc_write[d], pc_write_cond[d], ior_d[d], mem_read[d], mem_write[d],
            ir_write[d], mem_to_reg[d], reg_dst[d], reg_write[d], alu_src_a[d],
            alu_src_b[d], alu_op[d], pc_source[d]};
  endfunction

  // Phase list of one instruction: fetch wait, decode, then the class path.
  task automatic build_seq(input logic [5:0] o, input int lat);
    seq.delete();
    for (int i = 0; i <= lat; i++) seq.push_back(ST_IF);
    seq.push_back(ST_ID);
    case (o)
      T_R:    begin seq.push_back(ST_EX_R); seq.push_back(ST_WB_R); end
      T_ADDI: begin seq.push_back(ST_EX_I); seq.push_back(ST_WB_I); end
      T_LW: begin
        seq.push_back(ST_EX_MA);
        for (int i = 0; i <= lat; i++) seq.push_back(ST_MEM_RD);
        seq.push_back(ST_WB_MEM);
      end
      T_SW:   begin seq.push_back(ST_EX_MA); seq.push_back(ST_MEM_WR); end
      T_BEQ:  seq.push_back(ST_EX_BEQ);
      T_J:    seq.push_back(ST_EX_J);
      default: ;
    endcase
  endtask

  task automatic drive_check(input int d, input int s, input bit fin, input bit e,
                             input logic [5:0] o, input bit ill);
    exp_ctl_t ec, oc;
    @(negedge clk);
    en[d] = e;
    op[d] = o;
    zero = 1'($urandom);
    #1;
    ec = exp_ctl(s, fin, e);
    oc = obs_ctl(d);
    n_checks++;
    if (state[d] !== 4'(s)) begin
      n_fail++;
      $display("FAIL %s state dut%0d: got %0d expected %0d", cur_test, d, state[d], s);
    end
    n_checks++;
    if (oc !== ec) begin
      n_fail++;
      $display("FAIL %s controls dut%0d st%0d: got %h expected %h", cur_test, d, s, oc, ec);
    end
    n_checks++;
    if (illegal[d] !== ill) begin
      n_fail++;
      $display("FAIL %s illegal dut%0d: got %b expected %b", cur_test, d, illegal[d], ill);
    end
    n_checks++;
    if (led[d] !== led_exp[d]) begin
      n_fail++;
      $display("FAIL %s LED dut%0d: got %b expected %b", cur_test, d, led[d], led_exp[d]);
    end
    n_checks++;
    if (instr_cnt[d] !== cnt_exp[d]) begin
      n_fail++;
      $display("FAIL %s instr_cnt dut%0d: got %0d expected %0d", cur_test, d,
               instr_cnt[d], cnt_exp[d]);
    end
  endtask

  task automatic idle(input int d);
    drive_check(d, ST_IF, 1'b0, 1'b0, op[d], 1'b0);
  endtask

  // Runs one instruction, optionally stalling stall_len cycles before phase stall_at.
  task automatic run_instr(input int d, input logic [5:0] o, input int stall_at,
                           input int stall_len);
    bit legal;
    legal = is_legal(o);
    build_seq(o, lat_of(d));
    for (int k = 0; k < seq.size(); k++) begin
      if (k == stall_at)
        for (int j = 0; j < stall_len; j++) drive_check(d, seq[k], 1'b0, 1'b0, o, 1'b0);
      drive_check(d, seq[k], (seq[k] == ST_IF) && (k == lat_of(d)), 1'b1, o,
                  (seq[k] == ST_ID) && !legal);
      if (seq[k] == ST_ID) led_exp[d] = led_of(o);
    end
    if (legal) cnt_exp[d] = CNT_W'(cnt_exp[d] + 1);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    @(negedge clk);
    rst = 1'b1;
    en = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (obs_ctl(d) !== '0) begin
        n_fail++;
        $display("FAIL reset controls dut%0d: got %h expected 0", d, obs_ctl(d));
      end
      n_checks++;
      if (state[d] !== 4'd0 || led[d] !== 5'd0 || instr_cnt[d] !== '0 || illegal[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset status dut%0d: got st=%0d led=%b cnt=%0d ill=%b expected all 0",
                 d, state[d], led[d], instr_cnt[d], illegal[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    cnt_exp = '0;
    led_exp = '0;
  endtask

  task automatic check_led(input int d, input logic [4:0] want);
    n_checks++;
    if (led[d] !== want) begin
      n_fail++;
      $display("FAIL %s LED class dut%0d: got %b expected %b", cur_test, d, led[d], want);
    end
  endtask

  task automatic test_r_type();
    cur_test = "r_type";
    run_instr(0, T_R, -1, 0);
    idle(0);
    check_led(0, 5'b00001);
    n_checks++;
    if (instr_cnt[0] !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL r_type count: got %0d expected 1", instr_cnt[0]);
    end
  endtask

  task automatic test_lw();
    cur_test = "lw";
    run_instr(0, T_LW, -1, 0);
    idle(0);
    check_led(0, 5'b00100);
  endtask

  task automatic test_sw_beq();
    cur_test = "sw";
    run_instr(0, T_SW, -1, 0);
    idle(0);
    check_led(0, 5'b00010);
    cur_test = "beq";
    run_instr(0, T_BEQ, -1, 0);
    idle(0);
    check_led(0, 5'b01000);
  endtask

  task automatic test_illegal();
    cur_test = "illegal";
    run_instr(0, 6'b111111, -1, 0);
    idle(0);
    check_led(0, 5'b00000);
  endtask

  task automatic test_stall();
    cur_test = "stall_mem_rd";
    run_instr(0, T_LW, 5, 3);
    idle(0);
    cur_test = "stall_fetch";
    run_instr(0, T_ADDI, 1, 2);
    idle(0);
  endtask

  task automatic test_async_rst();
    cur_test = "async_rst";
    build_seq(T_R, 1);
    for (int k = 0; k < 5; k++) begin
      drive_check(0, seq[k], k == 1, 1'b1, T_R, 1'b0);
      if (k == 2) led_exp[0] = led_of(T_R);
    end
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (reg_write[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst RegWrite: got %b expected 0", reg_write[0]);
    end
    n_checks++;
    if (state[0] !== 4'd0 || instr_cnt[0] !== '0) begin
      n_fail++;
      $display("FAIL async_rst state/count: got st=%0d cnt=%0d expected 0/0", state[0], instr_cnt[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    en = 2'b00;
    cnt_exp = '0;
    led_exp = '0;
  endtask

  task automatic test_mem_lat0();
    cur_test = "mem_lat0";
    run_instr(1, T_R, -1, 0);
    run_instr(1, T_LW, 3, 2);
    run_instr(1, T_SW, -1, 0);
    run_instr(1, 6'b110011, -1, 0);
    run_instr(1, T_J, 0, 1);
    idle(1);
    check_led(1, 5'b10000);
  endtask

  task automatic test_random();
    logic [5:0] o;
    cur_test = "random";
    for (int i = 0; i < 150; i++) begin
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : rand_legal();
      run_instr(0, o, $urandom_range(0, 9), $urandom_range(0, 3));
    end
    idle(0);
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom) : rand_legal();
      run_instr(1, o, $urandom_range(0, 7), $urandom_range(0, 3));
    end
    idle(1);
  endtask

  task automatic test_wrap();
    test_reset();
    cur_test = "wrap";
    for (int i = 0; i < 255; i++) run_instr(0, rand_legal(), -1, 0);
    idle(0);
    n_checks++;
    if (instr_cnt[0] !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap count before: got %0d expected 255", instr_cnt[0]);
    end
    run_instr(0, T_BEQ, -1, 0);
    idle(0);
    n_checks++;
    if (instr_cnt[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap count after: got %0d expected 0", instr_cnt[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_r_type();
    test_lw();
    test_sw_beq();
    test_illegal();
    test_stall();
    test_async_rst();
    test_mem_lat0();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Control FSM that sequences the next-generation multicycle MIPS datapath. PC, instruction/data memory, register file and ALU are shared across cycles.
- Decodes `OP[5:0]` from the instruction register and drives the mux selects and write strobes for each phase.
- Reports the current state, the instruction class (LEDs) and a retired-instruction count for the seven-segment display mux.
- Supported opcodes: R (000000), LW (100011), SW (101011), BEQ (000100), J (000010), ADDI (001000).

Parameters:
- MEM_LAT, 1: extra wait cycles a block-RAM read needs before data is valid. Legal range 0..7.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock (the existing clk mux output: 100 ms clock or manual clock).
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  run enable; 0 stalls the FSM.
- OP  in  6  opcode field, IR[31:26].
- zero  in  1  ALU zero flag.
- PCWrite  out  1  unconditional PC write strobe.
- PCWriteCond  out  1  PC write strobe qualified by zero (branch).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load strobe.
- MemtoReg  out  1  register write-data select: 1 = MDR.
- RegDst  out  1  destination select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write strobe.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = sext, 11 = sext<<2.
- ALUop  out  2  code to the ALU control: 00 = add, 01 = sub, 10 = funct.
- PCSource  out  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump address.
- state  out  4  current state code.
- LED  out  5  instruction class, one-hot: [4] J, [3] BEQ, [2] LW, [1] SW, [0] R.
- illegal  out  1  one-cycle pulse when an unknown opcode is decoded.
- instr_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous, rst=1):
  - state = IF, wait counter = 0, LED = 0, instr_cnt = 0, illegal = 0.
  - All strobes and selects are 0 while rst is held.
- All outputs are Moore outputs decoded from the registered state. Default for every signal is 0 unless the state lists it.
- States and transitions:
  - IF:
    - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=00.
    - Held for MEM_LAT+1 cycles by the wait counter.
    - IRWrite=1 and PCWrite=1 only on the final cycle. Then go to ID.
  - ID:
    - Drives ALUSrcA=0, ALUSrcB=11, ALUop=00.
    - Latches LED class from OP.
    - Next state: R -> EX_R; LW/SW -> EX_MA; BEQ -> EX_BEQ; J -> EX_J; ADDI -> EX_I.
    - Unknown OP: illegal=1 for this cycle, LED=0, go to IF, not counted as retired.
  - EX_MA: ALUSrcA=1, ALUSrcB=10, ALUop=00. Go to MEM_RD if LW, MEM_WR if SW.
  - MEM_RD: MemRead=1, IorD=1. Held MEM_LAT+1 cycles, then WB_MEM.
  - WB_MEM: RegWrite=1, MemtoReg=1, RegDst=0. Go to IF.
  - MEM_WR: MemWrite=1, IorD=1 for exactly one cycle. Go to IF.
  - EX_R: ALUSrcA=1, ALUSrcB=00, ALUop=10. Go to WB_R.
  - WB_R: RegWrite=1, RegDst=1. Go to IF.
  - EX_I: ALUSrcA=1, ALUSrcB=10, ALUop=00. Go to WB_I.
  - WB_I: RegWrite=1, RegDst=0. Go to IF.
  - EX_BEQ: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01. Go to IF.
  - EX_J: PCWrite=1, PCSource=10. Go to IF.
- Retirement:
  - instr_cnt += 1 on each transition into IF from WB_MEM, MEM_WR, WB_R, WB_I, EX_BEQ or EX_J.
  - The counter wraps modulo 2^CNT_W.
- Cycles per instruction at MEM_LAT=1: R 5, ADDI 5, LW 7, SW 5, BEQ 4, J 4.
- Stall (en=0):
  - state, wait counter, LED and instr_cnt freeze.
  - PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite and illegal are forced to 0.
  - Selects and MemRead keep their state values.
  - When en returns to 1, operation resumes in the same state with the same wait count.
- MEM_LAT=0: IF and MEM_RD last one cycle. IRWrite/PCWrite assert in that single IF cycle.
- rst asserted mid-instruction: immediate return to IF. Any pending write strobe drops in the same cycle, with no clock edge required.

Decomposition:
- Shared header multi_defs.vh holds:
  - the opcode constants;
  - the 4-bit state codes (IF=0, ID=1, EX_MA=2, MEM_RD=3, WB_MEM=4, MEM_WR=5, EX_R=6, WB_R=7, EX_I=8, WB_I=9, EX_BEQ=10, EX_J=11);
  - the ALUSrcB, ALUop and PCSource encodings.
- One sub-module: multi_wait_cnt. It is a loadable down-counter with asynchronous reset, enable input and a done output, used by IF and MEM_RD.

Test Plan:
- Reset, then en=1 with OP=000000 and MEM_LAT=1 -> state sequence 0,0,1,6,7,0.
  - IRWrite and PCWrite are high only on the second IF cycle.
  - RegWrite=1 and RegDst=1 in WB_R; instr_cnt=1; LED=00001.
- OP=100011 -> sequence IF(2), ID, EX_MA, MEM_RD(2), WB_MEM.
  - IorD=1 in MEM_RD; MemtoReg=1 and RegWrite=1 in WB_MEM.
  - 7 cycles total; LED=00100.
- OP=101011 -> MemWrite high for exactly 1 cycle in state 5. OP=000100 -> EX_BEQ with PCWriteCond=1, PCSource=01, ALUop=01.
- OP=111111 -> illegal pulses 1 cycle in ID, state returns to 0, instr_cnt unchanged, LED=00000.
- Drop en for 3 cycles during MEM_RD -> state stays 3, all strobes 0. After en=1 the remaining wait cycle completes and the instruction retires normally.
- Assert rst asynchronously during WB_R -> RegWrite falls before the next edge, state=0, instr_cnt=0. Preload instr_cnt=0xFFFF and retire one instruction -> instr_cnt=0x0000.
